ahb_seg7_ctrl: RTL and testbench
================================

// Module: ahb_seg7_ctrl
// PURPOSE
//  AHB-Lite slave driving NUM_DIGITS 7-segment digits (hex decode + decimal point), static drive.
//  Adds per-digit blanking, per-digit DP and global enable over the fixed 8-digit display peripheral.
//  Optional global PWM brightness.
//  Sits on the Cortex-M0 AHB-Lite bus behind the address decoder; SEG_OUT goes to board HEX pins.
// PARAMETERS
//  NUM_DIGITS  8  digit count, 1..16
//  ACTIVE_LOW  1  1: lit segment drives 0 (DE2 boards); 0: lit drives 1
//  PWM_BITS    4  brightness resolution in bits (used only with SEG7_PWM_EN)
// PORTS
//  HCLK       in   1               bus clock
//  HRESETn    in   1               async active-low reset
//  HSEL       in   1               slave select
//  HREADY     in   1               bus ready; address phase sampled only when high
//  HADDR      in   32              address; only [3:0] decoded
//  HTRANS     in   2               transfer type; only HTRANS[1] (NONSEQ/SEQ) acts
//  HWRITE     in   1               1 = write
//  HSIZE      in   3               byte/half/word
//  HWDATA     in   32              write data, data phase
//  HREADYOUT  out  1               constant 1 (zero wait states)
//  HRESP      out  1               constant 0 (OKAY)
//  HRDATA     out  32              read data, data phase
//  SEG_OUT    out  NUM_DIGITS*8    digit d = [8d+7:8d] = {dp,g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset and clock: HRESETn async active-low, HCLK rising edge. Reset clears all registers and the PWM counter.
//  Address phase: when HREADY=1, register HSEL, HADDR[3:0], HTRANS[1], HWRITE and HSIZE.
//  Data phase access: access = rHSEL & rHTRANS1.
//  Register map (rHADDR[3:2]):
//   0x0 DATA_LO  nibbles for digits 0..7   (reset 0)
//   0x4 DATA_HI  nibbles for digits 8..15  (reset 0)
//   0x8 CTRL     [15:0] blank mask, [31:16] DP mask  (reset 0)
//   0xC BRIGHT   [31] enable, [PWM_BITS-1:0] duty    (reset 0x8000_0000 | all-ones duty)
//  Unimplemented bits: bits for digits >= NUM_DIGITS read 0 and ignore writes.
//  Writes:
//   - Happen on the data-phase HCLK edge, only when access & rHWRITE.
//   - Byte lanes follow HSIZE and HADDR[1:0]:
//     - byte: one lane, selected by [1:0];
//     - half: lanes 0-1 or 2-3, selected by [1];
//     - word: all four lanes.
//   - Unselected lanes keep their value.
//  Reads: HRDATA is a combinational mux on rHADDR[3:2]. It is valid in the data phase and reads 0 when not accessing.
//  Read-after-write: a read in the beat directly after a write returns the new value.
//  Segment computation, per digit d (lit = logical 1 before polarity):
//   - lit_segs = blank[d] | ~on ? 0 : {dp[d], hexdec(nibble d)}
//   - on = enable & pwm_on
//   - SEG_OUT = ACTIVE_LOW ? ~lit : lit
//  Output registering: SEG_OUT is registered, one HCLK after the register update.
//  SEG_OUT reset value: decode of 0 with DP off = 8'hC0 per digit (ACTIVE_LOW=1).
//  hexdec (gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
//  HREADY=0 in the address phase: no new sample; the previous sampled beat stays in effect.
//  Transfers with HTRANS IDLE or BUSY: no register write.
//  Reset mid-frame: all registers and PWM counter clear immediately; SEG_OUT goes to its reset value.
// CONFIGURATION
//  Macro SEG7_PWM_EN.
//  Defined:
//   - pwm_cnt (PWM_BITS wide) free-runs, +1 every HCLK, wraps to 0.
//   - pwm_on = (duty == all-ones) | (pwm_cnt < duty).
//   - duty 0 = dark.
//   - All-ones duty = always on.
//  Undefined:
//   - No counter; pwm_on = 1.
//   - BRIGHT duty bits read 0 and ignore writes; the enable bit still works.
// STRUCTURE
//  Package seg7_pkg: register offsets (DATA_LO/DATA_HI/CTRL/BRIGHT), HEXDEC lookup constants, BRIGHT enable bit index.
//  Sub-module seg7_hex_decode: combinational 4-bit to 7-segment (gfedcba active-high), one instance per digit via generate.
// TESTING
//  1 Release reset: every digit SEG_OUT = 8'hC0; reads: DATA_LO = 0, CTRL = 0, BRIGHT = 0x8000_000F.
//  2 Word write 0x0 <- 0x7654_3210, then read 0x0:
//    -> HRDATA 0x7654_3210; digit1 = 8'hF9, digit7 = 8'hF8.
//  3 Byte write addr 0x2 (HSIZE=0), HWDATA 0x00AB_0000, after DATA_LO = 0:
//    -> DATA_LO = 0x00AB_0000; digit4 = 8'h83 (b), digit5 = 8'h88 (A); others 8'hC0.
//  4 Half write addr 0xA <- 0x0001_0000, then half write addr 0x8 <- 0x0000_0008:
//    -> digit0 = 8'h40 (DP lit); digit3 = 8'hFF (blank).
//  5 [SEG7_PWM_EN] BRIGHT <- 0x8000_0004:
//    -> each digit lit exactly 4 of every 16 cycles.
//    BRIGHT <- 0x8000_0000 -> all 8'hFF. BRIGHT <- 0x0000_000F -> all 8'hFF.
//  6 Protocol stalls:
//    - Write with HTRANS=IDLE: no change.
//    - HREADY=0 during an address phase: that transfer is not sampled.
//    - Read 0x4 with NUM_DIGITS=8: returns 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Register map, hex-to-segment table and byte-lane helpers shared by the 7-segment AHB slave.
// Combinational constants and functions only; no state.
package seg7_pkg;

   localparam logic [1:0] REG_DATA_LO = 2'd0;
   localparam logic [1:0] REG_DATA_HI = 2'd1;
   localparam logic [1:0] REG_CTRL    = 2'd2;
   localparam logic [1:0] REG_BRIGHT  = 2'd3;

   localparam int BRIGHT_EN_BIT = 31;

   // gfedcba, active-high; index 15 is leftmost
   localparam logic [15:0][6:0] HEXDEC = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef struct packed {
      logic       sel;
      logic       trans1;
      logic       write;
      logic [2:0] size;
      logic [3:0] addr;
   } aphase_t;

   function automatic logic [31:0] nib_mask(input int ndig, input int first);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 8; i++)
         if (first + i < ndig) m[4*i +: 4] = 4'hF;
      return m;
   endfunction

   function automatic logic [15:0] dig_mask(input int ndig);
      logic [15:0] m;
      m = '0;
      for (int i = 0; i < 16; i++)
         if (i < ndig) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] lane_bits(input logic [2:0] size, input logic [1:0] a);
      logic [3:0] ln;
      case (size)
         3'b000:  ln = 4'b0001 << a;
         3'b001:  ln = a[1] ? 4'b1100 : 4'b0011;
         default: ln = 4'b1111;
      endcase
      return {{8{ln[3]}}, {8{ln[2]}}, {8{ln[1]}}, {8{ln[0]}}};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdat,
                                         input logic [31:0] mask);
      return (old & ~mask) | (wdat & mask);
   endfunction

endpackage

// File: rtl/ahb_seg7_ctrl_if.sv
// AHB-Lite slave port bundle for the 7-segment controller.
// Pure wiring; the slave always completes with zero wait states.
interface ahb_seg7_ctrl_if;
   logic        HSEL;
   logic        HREADY;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport master (output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
                   input  HREADYOUT, HRESP, HRDATA);
   modport slave  (input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
                   output HREADYOUT, HRESP, HRDATA);
endinterface

// File: rtl/seg7_hex_decode.sv
// 4-bit nibble to 7-segment pattern (gfedcba, active-high); purely combinational, zero latency.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] segs
);
   assign segs = HEXDEC[nib];
endmodule

// File: rtl/ahb_seg7_ctrl.sv
// AHB-Lite slave for static-drive 7-segment digits; optional PWM brightness under SEG7_PWM_EN.
// Zero wait states, never backpressures; SEG_OUT follows register writes by one HCLK.
module ahb_seg7_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter int PWM_BITS   = 4
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   ahb_seg7_ctrl_if.slave          bus,
   output logic [NUM_DIGITS*8-1:0] SEG_OUT
);
   localparam logic [31:0] LO_MASK   = nib_mask(NUM_DIGITS, 0);
   localparam logic [31:0] HI_MASK   = nib_mask(NUM_DIGITS, 8);
   localparam logic [31:0] CTRL_MASK = {dig_mask(NUM_DIGITS), dig_mask(NUM_DIGITS)};
   localparam logic [7:0]  LIT_RST   = {1'b0, HEXDEC[0]};
   localparam logic [7:0]  DIG_RST   = ACTIVE_LOW ? ~LIT_RST : LIT_RST;

   aphase_t     ap_q;
   logic        access, wr_en;
   logic [31:0] wmask, data_lo, data_hi, ctrl, bright_rd, rdata;
   logic        bright_en, pwm_on, seg_on;
   logic [NUM_DIGITS*8-1:0] seg_nxt;
   logic        unused_bits;

   assign unused_bits = ^{bus.HADDR[31:4], bus.HTRANS[0]};

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)         ap_q <= '0;
      else if (bus.HREADY)  ap_q <= '{sel: bus.HSEL, trans1: bus.HTRANS[1], write: bus.HWRITE,
                                      size: bus.HSIZE, addr: bus.HADDR[3:0]};
   end

   assign access = ap_q.sel & ap_q.trans1;
   assign wr_en  = access & ap_q.write;
   assign wmask  = lane_bits(ap_q.size, ap_q.addr[1:0]);

`ifdef SEG7_PWM_EN
   logic [PWM_BITS-1:0] duty, pwm_cnt;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         duty    <= '1;
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         if (wr_en && ap_q.addr[3:2] == REG_BRIGHT)
            duty <= (duty & ~wmask[PWM_BITS-1:0]) | (bus.HWDATA[PWM_BITS-1:0] & wmask[PWM_BITS-1:0]);
      end
   end

   // all-ones duty is a true 100%, not (2^N-1)/2^N
   assign pwm_on    = (&duty) | (pwm_cnt < duty);
   assign bright_rd = {bright_en, {(31-PWM_BITS){1'b0}}, duty};
`else
   assign pwm_on    = 1'b1;
   assign bright_rd = {bright_en, 31'b0};
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         data_lo   <= '0;
         data_hi   <= '0;
         ctrl      <= '0;
         bright_en <= 1'b1;
      end else if (wr_en) begin
         case (ap_q.addr[3:2])
            REG_DATA_LO: data_lo <= merge(data_lo, bus.HWDATA, wmask & LO_MASK);
            REG_DATA_HI: data_hi <= merge(data_hi, bus.HWDATA, wmask & HI_MASK);
            REG_CTRL:    ctrl    <= merge(ctrl, bus.HWDATA, wmask & CTRL_MASK);
            REG_BRIGHT:  if (wmask[BRIGHT_EN_BIT]) bright_en <= bus.HWDATA[BRIGHT_EN_BIT];
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      if (access) begin
         case (ap_q.addr[3:2])
            REG_DATA_LO: rdata = data_lo;
            REG_DATA_HI: rdata = data_hi;
            REG_CTRL:    rdata = ctrl;
            REG_BRIGHT:  rdata = bright_rd;
         endcase
      end
   end

   assign bus.HRDATA    = rdata;
   assign bus.HREADYOUT = 1'b1;
   assign bus.HRESP     = 1'b0;

   assign seg_on = bright_en & pwm_on;

   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
      logic [3:0] nib;
      logic [6:0] segs;
      logic [7:0] lit;

      if (d < 8) begin : g_lo
         assign nib = data_lo[4*d +: 4];
      end else begin : g_hi
         assign nib = data_hi[4*(d-8) +: 4];
      end

      seg7_hex_decode u_dec (.nib(nib), .segs(segs));

      assign lit = (ctrl[d] | ~seg_on) ? 8'h00 : {ctrl[16+d], segs};
      assign seg_nxt[8*d +: 8] = ACTIVE_LOW ? ~lit : lit;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) SEG_OUT <= {NUM_DIGITS{DIG_RST}};
      else          SEG_OUT <= seg_nxt;
   end

endmodule

// File: tb/tb_ahb_seg7_ctrl.sv
// Scoreboard bench for ahb_seg7_ctrl: 8 digits, active-low, default or SEG7_PWM_EN build.
module tb_ahb_seg7_ctrl;
   localparam logic [31:0] LO_M   = 32'hFFFF_FFFF;
   localparam logic [31:0] CTRL_M = 32'h00FF_00FF;
`ifdef SEG7_PWM_EN
   localparam logic [31:0] BR_M   = 32'h8000_000F;
`else
   localparam logic [31:0] BR_M   = 32'h8000_0000;
`endif

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [63:0] seg_out;
   ahb_seg7_ctrl_if bus();

   ahb_seg7_ctrl #(.NUM_DIGITS(8), .ACTIVE_LOW(1'b1), .PWM_BITS(4)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus), .SEG_OUT(seg_out));

   always #5 HCLK = ~HCLK;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] m_lo, m_ctrl, m_bright;
   logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic model_reset();
      m_lo = '0; m_ctrl = '0; m_bright = 32'h8000_000F & BR_M;
   endtask

   task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
      logic [3:0]  ln;
      logic [31:0] mk;
      if (sz == 3'd0)      ln = 4'b0001 << a[1:0];
      else if (sz == 3'd1) ln = a[1] ? 4'b1100 : 4'b0011;
      else                 ln = 4'b1111;
      for (int i = 0; i < 4; i++) mk[8*i +: 8] = {8{ln[i]}};
      case (a[3:2])
         2'd0: m_lo     = (m_lo & ~(mk & LO_M)) | (d & mk & LO_M);
         2'd2: m_ctrl   = (m_ctrl & ~(mk & CTRL_M)) | (d & mk & CTRL_M);
         2'd3: m_bright = (m_bright & ~(mk & BR_M)) | (d & mk & BR_M);
         default: ;
      endcase
   endtask

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      case (a[3:2])
         2'd0:    return m_lo;
         2'd2:    return m_ctrl;
         2'd3:    return m_bright;
         default: return 32'h0;
      endcase
   endfunction

   // only meaningful with duty all-ones or zero
   function automatic logic [63:0] exp_seg();
      logic [63:0] s;
      logic [7:0]  lit;
      logic        on;
`ifdef SEG7_PWM_EN
      on = m_bright[31] & (m_bright[3:0] != 4'h0);
`else
      on = m_bright[31];
`endif
      for (int d = 0; d < 8; d++) begin
         if (m_ctrl[d] || !on) lit = 8'h00;
         else                  lit = {m_ctrl[16+d], hex_tab[m_lo[4*d +: 4]]};
         s[8*d +: 8] = ~lit;
      end
      return s;
   endfunction

   task automatic idle_bus();
      bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
      bus.HADDR = '0;  bus.HSIZE = 3'd2;   bus.HREADY = 1'b1;
   endtask

   task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
      bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = wr;
      bus.HADDR = a;   bus.HSIZE = sz;     bus.HREADY = 1'b1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
      @(negedge HCLK); addr_phase(a, 1'b1, sz);
      @(negedge HCLK); idle_bus(); bus.HWDATA = d; model_write(a, sz, d);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] got);
      @(negedge HCLK); addr_phase(a, 1'b0, 3'd2);
      @(negedge HCLK); idle_bus(); got = bus.HRDATA;
   endtask

   task automatic settle();
      repeat (2) @(negedge HCLK);
   endtask

   task automatic test_reset();
      logic [31:0] got, e;
      HRESETn = 1'b0; idle_bus(); bus.HWDATA = '0; model_reset();
      repeat (3) @(negedge HCLK);
      n_cmp++; if (seg_out !== {8{8'hC0}}) begin n_err++; $display("FAIL reset_seg: got %h expected %h", seg_out, {8{8'hC0}}); end
      HRESETn = 1'b1;
      n_cmp++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin n_err++; $display("FAIL resp: got %b%b expected 10", bus.HREADYOUT, bus.HRESP); end
      for (int i = 0; i < 4; i++) begin
         if (i == 1) continue;
         exp_q.push_back(model_rd(32'(4*i)));
         do_read(32'(4*i), got);
         e = exp_q.pop_front();
         n_cmp++; if (got !== e) begin n_err++; $display("FAIL reset_rd%0d: got %h expected %h", i, got, e); end
      end
   endtask

   task automatic test_word_write();
      logic [31:0] got, e;
      do_write(32'h0, 3'd2, 32'h7654_3210);
      exp_q.push_back(model_rd(32'h0));
      do_read(32'h0, got);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL word_rd: got %h expected %h", got, e); end
      n_cmp++; if (seg_out[15:8] !== 8'hF9) begin n_err++; $display("FAIL word_dig1: got %h expected f9", seg_out[15:8]); end
      n_cmp++; if (seg_out[63:56] !== 8'hF8) begin n_err++; $display("FAIL word_dig7: got %h expected f8", seg_out[63:56]); end
      n_cmp++; if (seg_out !== exp_seg()) begin n_err++; $display("FAIL word_seg: got %h expected %h", seg_out, exp_seg()); end
   endtask

   task automatic test_byte_write();
      logic [31:0] got, e;
      do_write(32'h0, 3'd2, 32'h0);
      do_write(32'h2, 3'd0, 32'h00AB_0000);
      exp_q.push_back(model_rd(32'h0));
      do_read(32'h0, got);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL byte_rd: got %h expected %h", got, e); end
      n_cmp++; if (seg_out[39:32] !== 8'h83 || seg_out[47:40] !== 8'h88) begin n_err++; $display("FAIL byte_dig45: got %h expected 8883", seg_out[47:32]); end
      n_cmp++; if (seg_out !== exp_seg()) begin n_err++; $display("FAIL byte_seg: got %h expected %h", seg_out, exp_seg()); end
   endtask

   task automatic test_half_write();
      logic [31:0] got, e;
      do_write(32'hA, 3'd1, 32'h0001_0000);
      do_write(32'h8, 3'd1, 32'h0000_0008);
      exp_q.push_back(model_rd(32'h8));
      do_read(32'h8, got);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL half_rd: got %h expected %h", got, e); end
      n_cmp++; if (seg_out[7:0] !== 8'h40) begin n_err++; $display("FAIL half_dp0: got %h expected 40", seg_out[7:0]); end
      n_cmp++; if (seg_out[31:24] !== 8'hFF) begin n_err++; $display("FAIL half_blank3: got %h expected ff", seg_out[31:24]); end
      n_cmp++; if (seg_out !== exp_seg()) begin n_err++; $display("FAIL half_seg: got %h expected %h", seg_out, exp_seg()); end
   endtask

   task automatic test_bright();
      logic [31:0] got, e;
`ifdef SEG7_PWM_EN
      int lit_cnt;
      do_write(32'hC, 3'd2, 32'h8000_0004);
      settle();
      lit_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge HCLK);
         if (seg_out[15:8] != 8'hFF) lit_cnt++;
      end
      n_cmp++; if (lit_cnt !== 8) begin n_err++; $display("FAIL pwm_duty4: got %0d lit cycles expected 8", lit_cnt); end
      do_write(32'hC, 3'd2, 32'h8000_0000);
      settle();
      n_cmp++; if (seg_out !== {8{8'hFF}}) begin n_err++; $display("FAIL pwm_duty0: got %h expected all ff", seg_out); end
`endif
      do_write(32'hC, 3'd2, 32'h0000_000F);
      settle();
      n_cmp++; if (seg_out !== {8{8'hFF}}) begin n_err++; $display("FAIL bright_off: got %h expected all ff", seg_out); end
      exp_q.push_back(model_rd(32'hC));
      do_read(32'hC, got);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL bright_rd: got %h expected %h", got, e); end
      do_write(32'hC, 3'd2, 32'h8000_000F);
      settle();
      n_cmp++; if (seg_out !== exp_seg()) begin n_err++; $display("FAIL bright_on: got %h expected %h", seg_out, exp_seg()); end
   endtask

   task automatic test_protocol();
      logic [31:0] got, e;
      @(negedge HCLK);
      bus.HSEL = 1'b1; bus.HTRANS = 2'b00; bus.HWRITE = 1'b1; bus.HADDR = 32'h0; bus.HSIZE = 3'd2;
      @(negedge HCLK); idle_bus(); bus.HWDATA = 32'hDEAD_BEEF;
      n_cmp++; if (bus.HRDATA !== 32'h0) begin n_err++; $display("FAIL idle_rdata: got %h expected 0", bus.HRDATA); end
      exp_q.push_back(model_rd(32'h0));
      do_read(32'h0, got);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL idle_write: got %h expected %h", got, e); end
      @(negedge HCLK); addr_phase(32'h0, 1'b1, 3'd2); bus.HREADY = 1'b0;
      @(negedge HCLK); idle_bus(); bus.HWDATA = 32'h1234_5678;
      exp_q.push_back(model_rd(32'h0));
      do_read(32'h0, got);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL hready_low: got %h expected %h", got, e); end
      do_write(32'h4, 3'd2, 32'hFFFF_FFFF);
      exp_q.push_back(model_rd(32'h4));
      do_read(32'h4, got);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL data_hi: got %h expected %h", got, e); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got, e;
      @(negedge HCLK); addr_phase(32'h0, 1'b1, 3'd2);
      @(negedge HCLK); addr_phase(32'h0, 1'b0, 3'd2);
      bus.HWDATA = 32'hCAFE_F00D; model_write(32'h0, 3'd2, 32'hCAFE_F00D);
      exp_q.push_back(model_rd(32'h0));
      @(negedge HCLK); idle_bus(); got = bus.HRDATA;
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL raw_rd: got %h expected %h", got, e); end
      settle();
      n_cmp++; if (seg_out !== exp_seg()) begin n_err++; $display("FAIL raw_seg: got %h expected %h", seg_out, exp_seg()); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] got, e;
      do_write(32'h0, 3'd2, 32'h89AB_CDEF);
      settle();
      @(posedge HCLK); #2 HRESETn = 1'b0; model_reset();
      #1;
      n_cmp++; if (seg_out !== {8{8'hC0}}) begin n_err++; $display("FAIL midrst_seg: got %h expected %h", seg_out, {8{8'hC0}}); end
      @(negedge HCLK); HRESETn = 1'b1;
      exp_q.push_back(model_rd(32'h0));
      do_read(32'h0, got);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL midrst_rd: got %h expected %h", got, e); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_word_write();
      test_byte_write();
      test_half_write();
      test_bright();
      test_protocol();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
